// File: rtl/mesh_edge_port.sv
// Host-side adapter for one mesh router boundary port: independent TX and RX
// flit FIFOs between host and router, plus saturating transfer counters.

module mesh_edge_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Extra pointer bit tells a full FIFO apart from an empty one.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end
endmodule

module mesh_edge_port #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      host_tx_data,
  input  logic             host_tx_valid,
  output logic             host_tx_ready,
  output logic [31:0]      host_rx_data,
  output logic             host_rx_valid,
  input  logic             host_rx_ready,
  output logic [31:0]      net_dout,
  output logic             net_vout,
  input  logic             net_rin,
  input  logic [31:0]      net_din,
  input  logic             net_vin,
  output logic             net_rout,
  input  logic             clr_counts,
  output logic [CNT_W-1:0] tx_count,
  output logic [CNT_W-1:0] rx_count
);
  // Handshake: a flit moves on a rising clk edge where valid && ready; valid
  // never depends on ready, and an offered flit is held until it is taken.
  logic tx_full, tx_empty, tx_push, tx_pop;
  logic rx_full, rx_empty, rx_push, rx_pop;

  assign host_tx_ready = !rst && !tx_full;
  assign net_vout      = !tx_empty;
  assign tx_push       = host_tx_valid && host_tx_ready;
  assign tx_pop        = net_vout && net_rin;

  assign net_rout      = !rst && !rx_full;
  assign host_rx_valid = !rx_empty;
  assign rx_push       = net_vin && net_rout;
  assign rx_pop        = host_rx_valid && host_rx_ready;

  mesh_edge_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_push),
    .push_data (host_tx_data),
    .pop       (tx_pop),
    .full      (tx_full),
    .empty     (tx_empty),
    .head      (net_dout)
  );

  mesh_edge_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_push),
    .push_data (net_din),
    .pop       (rx_pop),
    .full      (rx_full),
    .empty     (rx_empty),
    .head      (host_rx_data)
  );

  // Clear wins over a same-cycle increment; counts stick at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_count <= '0;
      rx_count <= '0;
    end else if (clr_counts) begin
      tx_count <= '0;
      rx_count <= '0;
    end else begin
      if (tx_pop && (tx_count != '1)) tx_count <= tx_count + CNT_W'(1);
      if (rx_push && (rx_count != '1)) rx_count <= rx_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_mesh_edge_port.sv
// Self-checking bench for mesh_edge_port: vector table, handwritten corner
// sequences, and a scoreboard on both flit paths.

module tb_mesh_edge_port;
  localparam int DEPTH = 4;
  localparam int CW    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [31:0]   host_tx_data = '0;
  logic          host_tx_valid = 1'b0;
  logic          host_tx_ready;
  logic [31:0]   host_rx_data;
  logic          host_rx_valid;
  logic          host_rx_ready = 1'b0;
  logic [31:0]   net_dout;
  logic          net_vout;
  logic          net_rin = 1'b0;
  logic [31:0]   net_din = '0;
  logic          net_vin = 1'b0;
  logic          net_rout;
  logic          clr_counts = 1'b0;
  logic [CW-1:0] tx_count;
  logic [CW-1:0] rx_count;

  int checks   = 0;
  int failures = 0;

  logic [31:0]   tx_exp_q[$];
  logic [31:0]   rx_exp_q[$];
  logic [CW-1:0] m_tx_count = '0;
  logic [CW-1:0] m_rx_count = '0;

  typedef struct {
    logic        tv;
    logic [31:0] td;
    logic        rin;
    logic        vin;
    logic [31:0] nd;
    logic        rrdy;
    logic        e_trdy;
    logic        e_vout;
    logic        e_rout;
    logic        e_rxv;
  } vec_t;
  vec_t vecs[12];

  mesh_edge_port #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .host_tx_data  (host_tx_data),
    .host_tx_valid (host_tx_valid),
    .host_tx_ready (host_tx_ready),
    .host_rx_data  (host_rx_data),
    .host_rx_valid (host_rx_valid),
    .host_rx_ready (host_rx_ready),
    .net_dout      (net_dout),
    .net_vout      (net_vout),
    .net_rin       (net_rin),
    .net_din       (net_din),
    .net_vin       (net_vin),
    .net_rout      (net_rout),
    .clr_counts    (clr_counts),
    .tx_count      (tx_count),
    .rx_count      (rx_count)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got timeout/unexpected expected handshake", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  // Handshakes are predicted at the negedge, where inputs are already stable.
  always @(negedge clk) begin
    if (rst) begin
      tx_exp_q.delete();
      rx_exp_q.delete();
      m_tx_count <= '0;
      m_rx_count <= '0;
    end else begin
      if (net_vout && net_rin) begin
        if (tx_exp_q.size() == 0) fail_now("tx_extra_flit");
        else check("tx_flit", net_dout, tx_exp_q.pop_front());
      end
      if (host_rx_valid && host_rx_ready) begin
        if (rx_exp_q.size() == 0) fail_now("rx_extra_flit");
        else check("rx_flit", host_rx_data, rx_exp_q.pop_front());
      end
      if (host_tx_valid && host_tx_ready) tx_exp_q.push_back(host_tx_data);
      if (net_vin && net_rout) rx_exp_q.push_back(net_din);
      if (clr_counts) begin
        m_tx_count <= '0;
        m_rx_count <= '0;
      end else begin
        if (net_vout && net_rin && m_tx_count != '1) m_tx_count <= m_tx_count + 8'd1;
        if (net_vin && net_rout && m_rx_count != '1) m_rx_count <= m_rx_count + 8'd1;
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic tx_send(input logic [31:0] d);
    bit acc = 1'b0;
    host_tx_valid = 1'b1;
    host_tx_data  = d;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk);
      acc = host_tx_ready;
      tick();
    end
    host_tx_valid = 1'b0;
    if (!acc) fail_now("tx_send_timeout");
  endtask

  task automatic rx_send(input logic [31:0] d);
    bit acc = 1'b0;
    net_vin = 1'b1;
    net_din = d;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk);
      acc = net_rout;
      tick();
    end
    net_vin = 1'b0;
    if (!acc) fail_now("rx_send_timeout");
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((tx_exp_q.size() != 0 || rx_exp_q.size() != 0) && t < 100) begin
      tick();
      t++;
    end
    if (t >= 100) fail_now("drain_timeout");
    tick();
  endtask

  task automatic clear_counts();
    clr_counts = 1'b1;
    tick();
    clr_counts = 1'b0;
  endtask

  task automatic check_counts(input string name);
    check({name, "_tx_count"}, 32'(tx_count), 32'(m_tx_count));
    check({name, "_rx_count"}, 32'(rx_count), 32'(m_rx_count));
  endtask

  // ---------------- test ----------------
  initial begin
    int t0;
    bit stop_sink;

    vecs[0]  = '{1'b1, 32'h1111_0001, 1'b1, 1'b1, 32'h2222_0001, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 32'h1111_0002, 1'b0, 1'b1, 32'h2222_0002, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[2]  = '{1'b1, 32'h1111_0003, 1'b0, 1'b1, 32'h2222_0003, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[3]  = '{1'b1, 32'h1111_0004, 1'b0, 1'b1, 32'h2222_0004, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[4]  = '{1'b1, 32'h1111_0005, 1'b0, 1'b1, 32'h2222_0005, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 32'h1111_0005, 1'b1, 1'b1, 32'h2222_0005, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 32'h1111_0005, 1'b0, 1'b1, 32'h2222_0005, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    // reset values
    #1 rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("rst_host_tx_ready", 32'(host_tx_ready), 32'd0);
    check("rst_net_rout", 32'(net_rout), 32'd0);
    check("rst_net_vout", 32'(net_vout), 32'd0);
    check("rst_host_rx_valid", 32'(host_rx_valid), 32'd0);
    check("rst_net_dout", net_dout, 32'h0);
    check("rst_host_rx_data", host_rx_data, 32'h0);
    check("rst_tx_count", 32'(tx_count), 32'd0);
    check("rst_rx_count", 32'(rx_count), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_host_tx_ready", 32'(host_tx_ready), 32'd1);
    check("post_rst_net_rout", 32'(net_rout), 32'd1);
    tick();

    // single flit, minimum latency
    net_rin = 1'b1;
    tx_send(32'h12AB_CDEF);
    check("single_net_vout", 32'(net_vout), 32'd1);
    check("single_net_dout", net_dout, 32'h12AB_CDEF);
    tick();
    check("single_tx_count", 32'(tx_count), 32'd1);
    check("single_net_vout_after", 32'(net_vout), 32'd0);

    // vector table: fill, full boundary, pop-without-push-through, drain
    for (int i = 0; i < 12; i++) begin
      host_tx_valid = vecs[i].tv;
      host_tx_data  = vecs[i].td;
      net_rin       = vecs[i].rin;
      net_vin       = vecs[i].vin;
      net_din       = vecs[i].nd;
      host_rx_ready = vecs[i].rrdy;
      @(negedge clk);
      check($sformatf("vec%0d_host_tx_ready", i), 32'(host_tx_ready), 32'(vecs[i].e_trdy));
      check($sformatf("vec%0d_net_vout", i), 32'(net_vout), 32'(vecs[i].e_vout));
      check($sformatf("vec%0d_net_rout", i), 32'(net_rout), 32'(vecs[i].e_rout));
      check($sformatf("vec%0d_host_rx_valid", i), 32'(host_rx_valid), 32'(vecs[i].e_rxv));
      tick();
    end
    host_tx_valid = 1'b0;
    net_vin       = 1'b0;
    check_counts("table");

    // TX backpressure: A..D fill, E waits, head stays A
    net_rin = 1'b0;
    for (int i = 0; i < 4; i++) tx_send(32'hA000_0000 + i);
    host_tx_valid = 1'b1;
    host_tx_data  = 32'hA000_0004;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_host_tx_ready", 32'(host_tx_ready), 32'd0);
      check("bp_net_dout_stable", net_dout, 32'hA000_0000);
      tick();
    end
    net_rin = 1'b1;
    tx_send(32'hA000_0004);
    wait_drain();

    // RX backpressure: 6 flits, host stalled
    clear_counts();
    host_rx_ready = 1'b0;
    for (int i = 0; i < 4; i++) rx_send(32'hB000_0000 + i);
    @(negedge clk);
    check("rxbp_net_rout", 32'(net_rout), 32'd0);
    check("rxbp_rx_count", 32'(rx_count), 32'd4);
    tick();
    host_rx_ready = 1'b1;
    rx_send(32'hB000_0004);
    rx_send(32'hB000_0005);
    wait_drain();
    check("rxbp_rx_count_final", 32'(rx_count), 32'd6);

    // full-rate streaming both directions
    clear_counts();
    net_rin = 1'b1;
    host_rx_ready = 1'b1;
    t0 = int'($time);
    fork
      begin
        for (int i = 0; i < 100; i++) tx_send($urandom);
      end
      begin
        for (int i = 0; i < 100; i++) rx_send($urandom);
      end
    join
    check("stream_cycles", 32'((int'($time) - t0) / 10), 32'd100);
    wait_drain();
    check("stream_tx_count", 32'(tx_count), 32'd100);
    check("stream_rx_count", 32'(rx_count), 32'd100);

    // random backpressure on both sinks
    stop_sink = 1'b0;
    fork
      begin
        fork
          begin
            for (int i = 0; i < 40; i++) tx_send($urandom);
          end
          begin
            for (int i = 0; i < 40; i++) rx_send($urandom);
          end
        join
        stop_sink = 1'b1;
      end
      begin
        while (!stop_sink) begin
          net_rin       = 1'($urandom_range(0, 1));
          host_rx_ready = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join
    net_rin = 1'b1;
    host_rx_ready = 1'b1;
    wait_drain();
    check_counts("random");

    // counter saturation and clear priority
    clear_counts();
    for (int i = 0; i < 260; i++) tx_send(32'hC000_0000 + i);
    wait_drain();
    check("sat_tx_count", 32'(tx_count), 32'hFF);
    tx_send(32'hC000_1000);
    tick();
    check("sat_tx_count_hold", 32'(tx_count), 32'hFF);
    tx_send(32'hC000_2000);
    clr_counts = 1'b1;
    @(negedge clk);
    check("clr_same_cycle_pop", 32'(net_vout && net_rin), 32'd1);
    tick();
    clr_counts = 1'b0;
    check("clr_tx_count", 32'(tx_count), 32'd0);
    check("clr_rx_count", 32'(rx_count), 32'd0);

    // reset with queued flits
    net_rin = 1'b0;
    host_rx_ready = 1'b0;
    for (int i = 0; i < 3; i++) tx_send(32'hD000_0000 + i);
    for (int i = 0; i < 3; i++) rx_send(32'hE000_0000 + i);
    rst = 1'b1;
    #1;
    check("midrst_host_tx_ready", 32'(host_tx_ready), 32'd0);
    check("midrst_net_rout", 32'(net_rout), 32'd0);
    check("midrst_net_vout", 32'(net_vout), 32'd0);
    check("midrst_host_rx_valid", 32'(host_rx_valid), 32'd0);
    check("midrst_net_dout", net_dout, 32'h0);
    check("midrst_host_rx_data", host_rx_data, 32'h0);
    check("midrst_tx_count", 32'(tx_count), 32'd0);
    check("midrst_rx_count", 32'(rx_count), 32'd0);
    tick();
    rst = 1'b0;
    net_rin = 1'b1;
    host_rx_ready = 1'b1;
    @(negedge clk);
    check("after_rst_host_tx_ready", 32'(host_tx_ready), 32'd1);
    check("after_rst_net_rout", 32'(net_rout), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("after_rst_no_tx_flit", 32'(net_vout), 32'd0);
      check("after_rst_no_rx_flit", 32'(host_rx_valid), 32'd0);
    end

    check("final_tx_queue_empty", 32'(tx_exp_q.size()), 32'd0);
    check("final_rx_queue_empty", 32'(rx_exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
